// File: rtl/ones_comp_seq_arbiter.sv
// Two-requester round-robin front end to one shared external ripple-carry adder.
// Ones'-complement add/sub in two adder passes; build with OC_NEGZERO_FIX_EN to fold -0 into +0.
module ones_comp_seq_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_ovf,
  output logic             resp_id,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t           state_reg, state_next;
  logic             rr_reg;
  logic [WIDTH-1:0] a_reg, b_eff_reg, sum1_reg, result_reg;
  logic             c1_reg, ovf_reg, id_reg;

  logic             grant_any, grant_id, sel_sub;
  logic [WIDTH-1:0] sel_a, sel_b, pass2_result;
  logic             pass2_ovf;

  // The rr pointer only breaks ties; a lone valid requester always wins.
  assign grant_any = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? rr_reg : req1_valid;
  assign sel_a     = grant_id ? req1_a   : req0_a;
  assign sel_b     = grant_id ? req1_b   : req0_b;
  assign sel_sub   = grant_id ? req1_sub : req0_sub;

`ifdef OC_NEGZERO_FIX_EN
  assign pass2_result = (&adder_sum) ? '0 : adder_sum;
`else
  assign pass2_result = adder_sum;
`endif
  assign pass2_ovf = (a_reg[MSB] == b_eff_reg[MSB]) && (pass2_result[MSB] != a_reg[MSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = PASS1;
      PASS1:   state_next = PASS2;
      PASS2:   state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg     <= 1'b0;
      a_reg      <= '0;
      b_eff_reg  <= '0;
      id_reg     <= 1'b0;
      sum1_reg   <= '0;
      c1_reg     <= 1'b0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            a_reg     <= sel_a;
            b_eff_reg <= sel_sub ? ~sel_b : sel_b;
            id_reg    <= grant_id;
          end
        end
        PASS1: begin
          sum1_reg <= adder_sum;
          c1_reg   <= adder_cout;
        end
        PASS2: begin
          result_reg <= pass2_result;
          ovf_reg    <= pass2_ovf;
        end
        DONE: begin
          if (resp_ready) rr_reg <= ~id_reg;
        end
        default: ;
      endcase
    end
  end

  // Ready is qualified with rst_n so nothing is offered while reset is held.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp_valid  = 1'b0;
    resp_result = '0;
    resp_ovf    = 1'b0;
    resp_id     = 1'b0;
    adder_a     = '0;
    adder_b     = '0;
    adder_cin   = 1'b0;
    case (state_reg)
      IDLE: begin
        req0_ready = rst_n & grant_any & ~grant_id;
        req1_ready = rst_n & grant_any & grant_id;
      end
      PASS1: begin
        adder_a = a_reg;
        adder_b = b_eff_reg;
      end
      PASS2: begin
        adder_a   = sum1_reg;
        adder_cin = c1_reg;
      end
      DONE: begin
        resp_valid  = 1'b1;
        resp_result = result_reg;
        resp_ovf    = ovf_reg;
        resp_id     = id_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ones_comp_seq_arbiter.sv
// Bench for ones_comp_seq_arbiter: transaction-level reference model checked every cycle,
// plus directed cases with literal expectations and randomized traffic.
module tb_ones_comp_seq_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req0_sub = 1'b0, req1_valid = 1'b0, req1_sub = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_ready, req1_ready, resp_valid, resp_ovf, resp_id, adder_cin, adder_cout;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_result, adder_a, adder_b, adder_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External shared adder
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{W{1'b0}}, adder_cin};

  ones_comp_seq_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result), .resp_ovf(resp_ovf),
    .resp_id(resp_id), .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] beff;
    logic [W-1:0] sum1;
    logic         c1;
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  // Ones'-complement arithmetic from first principles: add, wrap the carry back in.
  function automatic exp_t oc_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t r;
    int s, t;
    r.beff = sub ? ~b : b;
    s = int'(a) + int'(r.beff);
    r.sum1 = s[W-1:0];
    r.c1 = (s >= (1 << W));
    t = r.c1 ? (s - (1 << W) + 1) : s;
    r.res = t[W-1:0];
`ifdef OC_NEGZERO_FIX_EN
    if (r.res == {W{1'b1}}) r.res = '0;
`endif
    r.ovf = (a[W-1] == r.beff[W-1]) && (r.res[W-1] != a[W-1]);
    return r;
  endfunction

  // Transaction model: busy flag plus cycles elapsed since acceptance.
  logic         m_busy = 1'b0;
  int           m_age = 0;
  logic         m_rr = 1'b0;
  logic         m_id = 1'b0;
  logic [W-1:0] m_a = '0;
  exp_t         m_x = '0;
  int           m_done = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_rr   <= 1'b0;
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        if ((req0_valid && req1_valid) ? m_rr : req1_valid) begin
          m_id <= 1'b1; m_a <= req1_a; m_x <= oc_model(req1_a, req1_b, req1_sub);
        end else begin
          m_id <= 1'b0; m_a <= req0_a; m_x <= oc_model(req0_a, req0_b, req0_sub);
        end
        m_busy <= 1'b1;
        m_age  <= 1;
      end
    end else if (m_age < 3) begin
      m_age <= m_age + 1;
    end else if (resp_ready) begin
      m_busy <= 1'b0;
      m_rr   <= ~m_id;
      m_done <= m_done + 1;
    end
  end

  always @(negedge clk) begin : cmp
    logic e_r0, e_r1, e_ci, e_rv, e_ov, e_id;
    logic [W-1:0] e_aa, e_ab, e_res;
    e_r0 = 0; e_r1 = 0; e_ci = 0; e_rv = 0; e_ov = 0; e_id = 0;
    e_aa = '0; e_ab = '0; e_res = '0;
    if (rst_n) begin
      if (!m_busy) begin
        e_r0 = req0_valid && (!req1_valid || !m_rr);
        e_r1 = req1_valid && (!req0_valid || m_rr);
      end else if (m_age == 1) begin
        e_aa = m_a; e_ab = m_x.beff;
      end else if (m_age == 2) begin
        e_aa = m_x.sum1; e_ci = m_x.c1;
      end else begin
        e_rv = 1; e_res = m_x.res; e_ov = m_x.ovf; e_id = m_id;
      end
    end
    chk("cmp_req0_ready", 32'(req0_ready), 32'(e_r0));
    chk("cmp_req1_ready", 32'(req1_ready), 32'(e_r1));
    chk("cmp_adder_a", 32'(adder_a), 32'(e_aa));
    chk("cmp_adder_b", 32'(adder_b), 32'(e_ab));
    chk("cmp_adder_cin", 32'(adder_cin), 32'(e_ci));
    chk("cmp_resp_valid", 32'(resp_valid), 32'(e_rv));
    chk("cmp_resp_result", 32'(resp_result), 32'(e_res));
    chk("cmp_resp_ovf", 32'(resp_ovf), 32'(e_ov));
    chk("cmp_resp_id", 32'(resp_id), 32'(e_id));
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_zero_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
    chk({nm, "_zero_adder"}, 32'({adder_a, adder_b, adder_cin}), 32'd0);
    chk({nm, "_zero_resp"}, 32'({resp_valid, resp_result, resp_ovf, resp_id}), 32'd0);
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Single-requester op with literal expectations; entered at posedge+1.
  task automatic run_op(input string nm, input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] eb, input logic [W-1:0] es1, input logic ec1,
                        input logic [W-1:0] er, input logic eo);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub; end
    @(negedge clk);
    chk({nm, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk({nm, "_resp_valid_latency"}, 32'(resp_valid), 32'(i == 3));
      if (i == 1) chk({nm, "_pass1_ab"}, 32'({adder_a, adder_b, adder_cin}), 32'({a, eb, 1'b0}));
      if (i == 2) chk({nm, "_pass2_ab"}, 32'({adder_a, adder_b, adder_cin}), 32'({es1, {W{1'b0}}, ec1}));
    end
    chk({nm, "_result"}, 32'(resp_result), 32'(er));
    chk({nm, "_ovf"}, 32'(resp_ovf), 32'(eo));
    chk({nm, "_id"}, 32'(resp_id), 32'(id));
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
  endtask

`ifdef OC_NEGZERO_FIX_EN
  localparam logic [W-1:0] T3_RES = 4'b0000;
`else
  localparam logic [W-1:0] T3_RES = 4'b1111;
`endif

  initial begin : stim
    logic         got, g;
    logic [W-1:0] held;
    exp_t         px;

    // Pin the reference model against hand-computed values.
    px = oc_model(4'b0011, 4'b0010, 1'b0);
    chk("model_t1", 32'({px.res, px.ovf}), 32'({4'b0101, 1'b0}));
    px = oc_model(4'b0110, 4'b0010, 1'b1);
    chk("model_t2", 32'({px.sum1, px.c1, px.res, px.ovf}), 32'({4'b0011, 1'b1, 4'b0100, 1'b0}));
    px = oc_model(4'b0101, 4'b0101, 1'b1);
    chk("model_t3", 32'(px.res), 32'(T3_RES));
    px = oc_model(4'b0101, 4'b0100, 1'b0);
    chk("model_t4", 32'({px.res, px.ovf}), 32'({4'b1001, 1'b1}));

    #2 chk_all_zero("reset");
    do_reset();

    run_op("t1_add", 1'b0, 4'b0011, 4'b0010, 1'b0, 4'b0010, 4'b0101, 1'b0, 4'b0101, 1'b0);
    run_op("t2_sub", 1'b1, 4'b0110, 4'b0010, 1'b1, 4'b1101, 4'b0011, 1'b1, 4'b0100, 1'b0);
    run_op("t3_negzero", 1'b0, 4'b0101, 4'b0101, 1'b1, 4'b1010, 4'b1111, 1'b0, T3_RES, 1'b0);
    run_op("t4_ovf", 1'b0, 4'b0101, 4'b0100, 1'b0, 4'b0100, 4'b1001, 1'b0, 4'b1001, 1'b1);

    // Both requesters hammering, first result stalled.
    do_reset();
    req0_valid = 1; req1_valid = 1;
    req0_a = 4'b0001; req0_b = 4'b0010; req0_sub = 0;
    req1_a = 4'b0111; req1_b = 4'b0011; req1_sub = 1;
    for (int k = 0; k < 4; k++) begin
      got = 0; g = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin got = 1; g = req1_ready; end
      end
      chk("t5_grant_seen", 32'(got), 32'd1);
      chk("t5_grant_order", 32'(g), 32'(k % 2));
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (resp_valid) got = 1;
      end
      chk("t5_resp_seen", 32'(got), 32'd1);
      chk("t5_resp_id", 32'(resp_id), 32'(g));
      if (k == 0) begin
        held = resp_result;
        chk("t5_first_result", 32'(held), 32'(4'b0011));
        repeat (4) begin
          @(negedge clk);
          chk("t5_stall_valid", 32'(resp_valid), 32'd1);
          chk("t5_stall_result", 32'(resp_result), 32'(held));
        end
      end
      resp_ready = 1;
      @(posedge clk); #1;
      resp_ready = 0;
      if (k == 3) begin req0_valid = 0; req1_valid = 0; end
    end

    // Reset during PASS1
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 4'b0010; req0_b = 4'b0001; req0_sub = 0;
    @(negedge clk);
    chk("t6_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 0;
    #2 rst_n = 0; req0_valid = 1; req1_valid = 1;
    #1 chk_all_zero("t6_async");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("t6_regrant", 32'({req0_ready, req1_ready}), 32'({1'b1, 1'b0}));
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;

    // Randomized traffic against the model
    repeat (3000) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom_range(0, 1));
      req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom_range(0, 1));
      resp_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("rand_completions", 32'(m_done > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
